// File: rtl/sap2_pkg.sv
// Shared definitions for the sap2_mini program-RAM loader: default widths,
// controller state encoding and the idle levels of the RAM strobes.
package sap2_pkg;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 12;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StFlush,
        StRdAddr,
        StRdLast,
        StCheck,
        StFin
    } state_e;

    // RAM strobe levels while the loader does not own the RAM
    localparam logic MEM_PROG_IDLE = 1'b1;  // active-low program strobe
    localparam logic MEM_WE_IDLE   = 1'b0;
    localparam logic MEM_CE_IDLE   = 1'b0;

endpackage

// File: rtl/sap2_addr_ctr.sv
// Loadable wrapping address counter with a remaining-word down-counter.
// Shared by the write pass and the verify read pass of the loader.
module sap2_addr_ctr #(
    parameter int unsigned AW = 8
) (
    input  logic          clk_i,
    input  logic          clr_ni,
    input  logic          load_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [AW:0]   load_cnt_i,
    input  logic          step_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o,
    output logic          empty_o
);

    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   rem_q, rem_d;

    // Load has priority over step; address wraps modulo 2^AW
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = load_addr_i;
            rem_d  = load_cnt_i;
        end else if (step_i) begin
            addr_d = addr_q + AW'(1);
            rem_d  = rem_q - (AW+1)'(1);
        end
    end

    // Counter state, synchronous active-low clear
    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o  = addr_q;
    assign last_o  = (rem_q == (AW+1)'(1));
    assign empty_o = (rem_q == '0);

endmodule

// File: rtl/sap2_ram_loader.sv
// Streams words into consecutive program-RAM addresses, keeps a running
// checksum and optionally reads the range back to verify it.
module sap2_ram_loader
    import sap2_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] count,
    input  logic          verify,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          mem_prog,
    output logic          mem_we,
    output logic          mem_ce,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_out,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] csum
);

    state_e        state_q;
    logic [AW-1:0] base_q;
    logic [AW:0]   cnt_q;
    logic          verify_q;
    logic [DW-1:0] csum_q, rsum_q;
    logic          rd_v1_q, rd_v2_q;  // read address issued / read data valid
    logic          in_ready_q, busy_q, done_q, err_q;
    logic          mem_prog_q, mem_we_q, mem_ce_q;
    logic [AW-1:0] mem_a_q;
    logic [DW-1:0] mem_d_q;

    logic [AW:0]   cnt_eff;
    logic          hs;
    logic          ctr_load, ctr_step, ctr_last, ctr_empty;
    logic [AW-1:0] ctr_load_addr, ctr_addr;
    logic [AW:0]   ctr_load_cnt;

    // count of zero stands for a full 2^AW-word load
    assign cnt_eff = (count == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, count};
    assign hs      = in_valid & in_ready_q;

    // Counter control: write pass loads on start, read pass loads on leaving FLUSH
    always_comb begin
        ctr_load      = 1'b0;
        ctr_step      = 1'b0;
        ctr_load_addr = base;
        ctr_load_cnt  = cnt_eff;
        unique case (state_q)
            StIdle:   ctr_load = start;
            StWrite:  ctr_step = hs;
            StFlush: begin
                // base itself is issued directly on the FLUSH exit edge
                ctr_load      = 1'b1;
                ctr_load_addr = base_q + AW'(1);
                ctr_load_cnt  = cnt_q - (AW+1)'(1);
            end
            StRdAddr: ctr_step = ~ctr_empty;
            default:  ;
        endcase
    end

    sap2_addr_ctr #(
        .AW (AW)
    ) u_addr_ctr (
        .clk_i       (clk),
        .clr_ni      (clr_n),
        .load_i      (ctr_load),
        .load_addr_i (ctr_load_addr),
        .load_cnt_i  (ctr_load_cnt),
        .step_i      (ctr_step),
        .addr_o      (ctr_addr),
        .last_o      (ctr_last),
        .empty_o     (ctr_empty)
    );

    // Controller FSM with registered RAM strobes and status outputs
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= StIdle;
            base_q     <= '0;
            cnt_q      <= '0;
            verify_q   <= 1'b0;
            csum_q     <= '0;
            rsum_q     <= '0;
            rd_v1_q    <= 1'b0;
            rd_v2_q    <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_prog_q <= MEM_PROG_IDLE;
            mem_we_q   <= MEM_WE_IDLE;
            mem_ce_q   <= MEM_CE_IDLE;
            mem_a_q    <= '0;
            mem_d_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q     <= base;
                        cnt_q      <= cnt_eff;
                        verify_q   <= verify;
                        csum_q     <= '0;
                        rsum_q     <= '0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        mem_prog_q <= 1'b0;
                        state_q    <= StWrite;
                    end
                end
                StWrite: begin
                    mem_we_q <= hs;
                    if (hs) begin
                        mem_a_q <= ctr_addr;
                        mem_d_q <= in_data;
                        csum_q  <= csum_q + in_data;
                        if (ctr_last) begin
                            in_ready_q <= 1'b0;
                            state_q    <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    mem_we_q   <= MEM_WE_IDLE;
                    mem_d_q    <= '0;
                    mem_prog_q <= MEM_PROG_IDLE;
                    if (verify_q) begin
                        mem_ce_q <= 1'b1;
                        mem_a_q  <= base_q;
                        rd_v1_q  <= 1'b1;
                        state_q  <= StRdAddr;
                    end else begin
                        mem_a_q <= '0;
                        state_q <= StFin;
                    end
                end
                StRdAddr: begin
                    if (ctr_empty) begin
                        rd_v1_q <= 1'b0;
                        state_q <= StRdLast;
                    end else begin
                        mem_a_q <= ctr_addr;
                    end
                end
                StRdLast: begin
                    mem_ce_q <= MEM_CE_IDLE;
                    mem_a_q  <= '0;
                    state_q  <= StCheck;
                end
                StCheck: begin
                    if (rsum_q == csum_q) begin
                        state_q <= StFin;
                    end else begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StFin: begin
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    mem_prog_q <= MEM_PROG_IDLE;
                    mem_we_q   <= MEM_WE_IDLE;
                    mem_ce_q   <= MEM_CE_IDLE;
                    mem_a_q    <= '0;
                    mem_d_q    <= '0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            // Registered RAM read: data is valid the cycle after its address was sampled
            rd_v2_q <= rd_v1_q;
            if (rd_v2_q) begin
                rsum_q <= rsum_q + mem_out;
            end
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign csum     = csum_q;
    assign mem_prog = mem_prog_q;
    assign mem_we   = mem_we_q;
    assign mem_ce   = mem_ce_q;
    assign mem_a    = mem_a_q;
    assign mem_d    = mem_d_q;

endmodule
